sirv_debug_csr_trig: RTL

SIRV_DEBUG_CSR_TRIG -- requirements
Module: sirv_debug_csr_trig

---
 rtl/sirv_debug_csr_trig.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sirv_debug_csr_trig.sv
// Debug-mode CSR block: mode FSM, dcsr/dpc/dscratch and a small bank of
// instruction-address triggers (tselect/tdata1/tdata2) with combinational match.
module sirv_debug_csr_trig #(
    parameter int PC_SIZE  = 32,
    parameter int TRIG_NUM = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PC_SIZE-1:0] cmt_dpc,
    input  logic               cmt_dpc_ena,
    input  logic [2:0]         cmt_dcause,
    input  logic               cmt_dcause_ena,
    input  logic               cmt_dret_ena,
    input  logic               dbg_irq_r,
    input  logic               wr_dcsr_ena,
    input  logic               wr_dpc_ena,
    input  logic               wr_dscratch_ena,
    input  logic               wr_tselect_ena,
    input  logic               wr_tdata1_ena,
    input  logic               wr_tdata2_ena,
    input  logic [31:0]        wr_csr_nxt,
    input  logic [PC_SIZE-1:0] chk_pc,
    input  logic               chk_pc_vld,
    output logic [31:0]        dcsr_r,
    output logic [PC_SIZE-1:0] dpc_r,
    output logic [31:0]        dscratch_r,
    output logic [31:0]        tselect_r,
    output logic [31:0]        tdata1_r,
    output logic [31:0]        tdata2_r,
    output logic               dbg_mode,
    output logic               dbg_halt_r,
    output logic               dbg_step_r,
    output logic               dbg_ebreakm_r,
    output logic               dbg_stopcycle,
    output logic               trig_hit,
    output logic [1:0]         trig_hit_idx
);

    typedef enum logic {ST_RUN = 1'b0, ST_DEBUG = 1'b1} mode_e;

    // Trigger storage is sized for the architectural maximum of four; entries
    // at or above TRIG_NUM are never written and stay at their reset value.
    localparam int MAX_TRIG = 4;

    mode_e state_q, state_nxt;
    logic  enter_dbg, leave_dbg;

    logic [2:0]         cause_q;
    logic               halt_q, step_q, ebreakm_q, stoptime_q;
    logic [PC_SIZE-1:0] dpc_q;
    logic [31:0]        dscratch_q;
    logic [1:0]         tselect_q;

    logic               trg_dmode   [MAX_TRIG];
    logic               trg_hit     [MAX_TRIG];
    logic               trg_action  [MAX_TRIG];
    logic [3:0]         trg_match   [MAX_TRIG];
    logic               trg_m       [MAX_TRIG];
    logic               trg_execute [MAX_TRIG];
    logic [PC_SIZE-1:0] trg_addr    [MAX_TRIG];

    logic [MAX_TRIG-1:0] t1_wr, t2_wr, match_vec;
    logic [3:0]          wr_match;
    logic [31:0]         addr_ext;

    // The LSB of the committed PC is architecturally zero in dpc.
    logic unused_dpc_lsb;
    assign unused_dpc_lsb = cmt_dpc[0];

    // Mode state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_nxt;
    end

    // Mode next-state: dret outranks a concurrent debug entry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state_q;
        enter_dbg = 1'b0;
        leave_dbg = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (cmt_dcause_ena && (cmt_dcause != 3'd0) && !cmt_dret_ena) begin
                    state_nxt = ST_DEBUG;
                    enter_dbg = 1'b1;
                end
            end
            ST_DEBUG: begin
                if (cmt_dret_ena) begin
                    state_nxt = ST_RUN;
                    leave_dbg = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign dbg_mode = (state_q == ST_DEBUG);

    // dcsr state: cause tracks debug entry/exit, control bits are CSR-writable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            cause_q    <= 3'd0;
            halt_q     <= 1'b0;
            step_q     <= 1'b0;
            ebreakm_q  <= 1'b0;
            stoptime_q <= 1'b0;
        end else begin
            if (enter_dbg)      cause_q <= cmt_dcause;
            else if (leave_dbg) cause_q <= 3'd0;
            if (wr_dcsr_ena) begin
                halt_q     <= wr_csr_nxt[3];
                step_q     <= wr_csr_nxt[2];
                ebreakm_q  <= wr_csr_nxt[15];
                stoptime_q <= wr_csr_nxt[9];
            end
        end
    end

    // dpc, dscratch and tselect registers; commit outranks a CSR write to dpc.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dpc_q      <= '0;
            dscratch_q <= '0;
            tselect_q  <= 2'd0;
        end else begin
            if (cmt_dpc_ena && !dbg_mode) dpc_q <= {cmt_dpc[PC_SIZE-1:1], 1'b0};
            else if (wr_dpc_ena)          dpc_q <= {wr_csr_nxt[PC_SIZE-1:1], 1'b0};
            if (wr_dscratch_ena) dscratch_q <= wr_csr_nxt;
            if (wr_tselect_ena && (wr_csr_nxt < 32'(TRIG_NUM))) tselect_q <= wr_csr_nxt[1:0];
        end
    end

    // Per-trigger write strobes and address match; dmode triggers are locked outside debug.
    always_comb begin
        t1_wr     = '0;
        t2_wr     = '0;
        match_vec = '0;
        for (int i = 0; i < MAX_TRIG; i++) begin
            if (i < TRIG_NUM) begin
                t1_wr[i] = wr_tdata1_ena && (tselect_q == 2'(i)) && !(trg_dmode[i] && !dbg_mode);
                t2_wr[i] = wr_tdata2_ena && (tselect_q == 2'(i)) && !(trg_dmode[i] && !dbg_mode);
                if (chk_pc_vld && !dbg_mode && trg_execute[i] && trg_m[i]) begin
                    case (trg_match[i])
                        4'd0:    match_vec[i] = (chk_pc == trg_addr[i]);
                        4'd2:    match_vec[i] = (chk_pc >= trg_addr[i]);
                        4'd3:    match_vec[i] = (chk_pc <  trg_addr[i]);
                        default: match_vec[i] = 1'b0;
                    endcase
                end
            end
        end
    end

    // Lowest-index matching trigger wins.
    always_comb begin
        trig_hit     = |match_vec;
        trig_hit_idx = 2'd0;
        for (int i = MAX_TRIG - 1; i >= 0; i--) begin
            if (match_vec[i]) trig_hit_idx = 2'(i);
        end
    end

    // Only the encodings equal / greater-or-equal / less-than are kept.
    assign wr_match = ((wr_csr_nxt[10:7] == 4'd0) || (wr_csr_nxt[10:7] == 4'd2) ||
                       (wr_csr_nxt[10:7] == 4'd3)) ? wr_csr_nxt[10:7] : 4'd0;

    // Trigger bank: CSR writes, and sticky hit flag for the winning trigger.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_TRIG; i++) begin
            // NOTE: this small register array is reset because tdata1 must read a defined value after reset.
            if (!rst_n) begin
                trg_dmode[i]   <= 1'b0;
                trg_hit[i]     <= 1'b0;
                trg_action[i]  <= 1'b0;
                trg_match[i]   <= 4'd0;
                trg_m[i]       <= 1'b0;
                trg_execute[i] <= 1'b0;
                trg_addr[i]    <= '0;
            end else begin
                if (t1_wr[i]) begin
                    if (dbg_mode) trg_dmode[i] <= wr_csr_nxt[27];
                    trg_hit[i]     <= wr_csr_nxt[20];
                    trg_action[i]  <= wr_csr_nxt[12];
                    trg_match[i]   <= wr_match;
                    trg_m[i]       <= wr_csr_nxt[6];
                    trg_execute[i] <= wr_csr_nxt[2];
                end else if (trig_hit && (trig_hit_idx == 2'(i))) begin
                    trg_hit[i] <= 1'b1;
                end
                if (t2_wr[i]) trg_addr[i] <= wr_csr_nxt[PC_SIZE-1:0];
            end
        end
    end

    // Zero-extend the selected match address to CSR width.
    always_comb begin
        addr_ext              = '0;
        addr_ext[PC_SIZE-1:0] = trg_addr[tselect_q];
    end

    assign tdata2_r = addr_ext;
    assign tdata1_r = {4'd2, trg_dmode[tselect_q], 6'd0, trg_hit[tselect_q], 7'd0,
                       trg_action[tselect_q], 1'b0, trg_match[tselect_q], trg_m[tselect_q],
                       3'd0, trg_execute[tselect_q], 2'd0};
    assign tselect_r = {30'd0, tselect_q};

    assign dcsr_r = {2'b01, 14'd0, {4{ebreakm_q}}, 1'b0, 1'b1, stoptime_q, cause_q,
                     dbg_irq_r, 1'b0, halt_q, step_q, 2'b11};
    assign dpc_r         = dpc_q;
    assign dscratch_r    = dscratch_q;
    assign dbg_halt_r    = halt_q;
    assign dbg_step_r    = step_q;
    assign dbg_ebreakm_r = ebreakm_q;
    assign dbg_stopcycle = 1'b1;

endmodule
